// File: rtl/led_pio_ctrl.sv
// Avalon-MM LED PIO: DATA/SET/CLEAR, per-channel blink mask with a shared blink period,
// and optional global brightness PWM compiled in with `define LED_PIO_PWM_EN.
module led_pio_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PERIOD_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_MASK   = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_DUTY   = 3'd5;
  localparam logic [2:0] ADDR_OUT    = 3'd6;

  logic                w_wr;
  logic                w_wrData;
  logic                w_wrSet;
  logic                w_wrClear;
  logic                w_wrMask;
  logic                w_wrPeriod;
  logic [WIDTH-1:0]    w_wdata;
  logic [WIDTH-1:0]    w_nextOut;
  logic                w_pwmOn;
  logic [31:0]         w_dutyRd;
  logic                w_unusedBits;

  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_mask;
  logic [WIDTH-1:0]    r_out;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_phase;

  assign w_wr       = chipselect & ~write_n;
  assign w_wrData   = w_wr & (address == ADDR_DATA);
  assign w_wrSet    = w_wr & (address == ADDR_SET);
  assign w_wrClear  = w_wr & (address == ADDR_CLEAR);
  assign w_wrMask   = w_wr & (address == ADDR_MASK);
  assign w_wrPeriod = w_wr & (address == ADDR_PERIOD);
  assign w_wdata    = writedata[WIDTH-1:0];

  // Upper writedata bits are legitimately ignored for narrow configurations.
  assign w_unusedBits = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (w_wrData) begin
      r_data <= w_wdata;
    end else if (w_wrSet) begin
      r_data <= r_data | w_wdata;
    end else if (w_wrClear) begin
      r_data <= r_data & ~w_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_wrMask) begin
      r_mask <= w_wdata;
    end
  end

  // Each blink phase lasts period+1 cycles; a period write restarts in the "on" phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= '0;
      r_cnt    <= '0;
      r_phase  <= 1'b1;
    end else if (w_wrPeriod) begin
      r_period <= writedata[PERIOD_W-1:0];
      r_cnt    <= '0;
      r_phase  <= 1'b1;
    end else if (r_period == '0) begin
      r_cnt    <= '0;
      r_phase  <= 1'b1;
    end else if (r_cnt == r_period) begin
      r_cnt    <= '0;
      r_phase  <= ~r_phase;
    end else begin
      r_cnt    <= r_cnt + PERIOD_W'(1);
    end
  end

`ifdef LED_PIO_PWM_EN
  logic [7:0] r_duty;
  logic [7:0] r_pwmCnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty <= 8'hFF;
    end else if (w_wr && (address == ADDR_DUTY)) begin
      r_duty <= writedata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwmCnt <= 8'd0;
    end else begin
      r_pwmCnt <= r_pwmCnt + 8'd1;
    end
  end

  // Full scale is special-cased so DUTY=FF is truly always on.
  assign w_pwmOn  = (r_duty == 8'hFF) | (r_pwmCnt < r_duty);
  assign w_dutyRd = {24'd0, r_duty};
`else
  assign w_pwmOn  = 1'b1;
  assign w_dutyRd = 32'd0;
`endif

  assign w_nextOut = r_data & (~r_mask | {WIDTH{r_phase}}) & {WIDTH{w_pwmOn}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_nextOut;
    end
  end

  assign out_port = r_out;

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:   readdata = 32'(r_data);
      ADDR_MASK:   readdata = 32'(r_mask);
      ADDR_PERIOD: readdata = 32'(r_period);
      ADDR_DUTY:   readdata = w_dutyRd;
      ADDR_OUT:    readdata = 32'(r_out);
      default:     readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_led_pio_ctrl.sv
// Scoreboard bench for led_pio_ctrl: a cycle-count based reference model predicts reads and
// out_port; a WIDTH=4 instance on the same bus must match the model's low nibble.
module tb_led_pio_ctrl;

  localparam int          W     = 8;
  localparam int          PW    = 24;
  localparam logic [31:0] WMASK = 32'h0000_00FF;
  localparam logic [31:0] PMASK = 32'h00FF_FFFF;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] out_port;
  logic [31:0] readdata4;
  logic [3:0]  out4;

  led_pio_ctrl #(.WIDTH(W), .PERIOD_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  led_pio_ctrl #(.WIDTH(4), .PERIOD_W(PW)) dut4 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata4), .out_port(out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;
    logic [2:0]  addr;
    logic [31:0] exp;
  } expItem_t;

  expItem_t    rdQ[$];
  logic [31:0] outQ[$];
  event        rdEv;
  int          nChecks = 0;
  int          nFails  = 0;

  // Reference model state, expressed as register values plus elapsed cycle counts.
  longint m_data, m_mask, m_period, m_duty, m_out;
  longint m_edges, m_pStart;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelOut();
    bit ph, pw;
    if (m_period == 0) ph = 1'b1;
    else ph = (((m_edges - m_pStart) / (m_period + 1)) % 2) == 0;
`ifdef LED_PIO_PWM_EN
    pw = (m_duty == 255) || ((m_edges % 256) < m_duty);
`else
    pw = 1'b1;
`endif
    return 32'(m_data) & (~32'(m_mask) | (ph ? WMASK : 32'd0)) & (pw ? WMASK : 32'd0);
  endfunction

  function automatic logic [31:0] expRead(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_data);
      3'd3: return 32'(m_mask);
      3'd4: return 32'(m_period);
`ifdef LED_PIO_PWM_EN
      3'd5: return 32'(m_duty);
`endif
      3'd6: return 32'(m_out);
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    m_data = 0; m_mask = 0; m_period = 0; m_duty = 255; m_out = 0;
    m_edges = 0; m_pStart = 0;
    outQ.delete();
  endtask

  task automatic modelStep();
    logic [31:0] nextOut;
    logic [31:0] wd;
    if (!reset_n) begin
      modelReset();
      return;
    end
    nextOut = modelOut();
    wd = writedata;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_data = longint'(wd & WMASK);
        3'd1: m_data = longint'((32'(m_data) | wd) & WMASK);
        3'd2: m_data = longint'(32'(m_data) & ~wd & WMASK);
        3'd3: m_mask = longint'(wd & WMASK);
        3'd4: begin m_period = longint'(wd & PMASK); m_pStart = m_edges + 1; end
`ifdef LED_PIO_PWM_EN
        3'd5: m_duty = longint'(wd & 32'hFF);
`endif
        default: ;
      endcase
    end
    m_edges++;
    m_out = longint'(nextOut);
    outQ.push_back(nextOut);
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    modelStep();
  end

  // Read monitor: the 4-bit instance must show the low nibble of the channel registers.
  initial forever begin
    expItem_t it;
    logic [31:0] e4;
    @(rdEv);
    while (rdQ.size() > 0) begin
      it = rdQ.pop_front();
      if (it.kind == 0) begin
        e4 = (it.addr == 3'd0 || it.addr == 3'd3 || it.addr == 3'd6) ? (it.exp & 32'hF) : it.exp;
        checkOutput(it.name, readdata, it.exp);
        checkOutput({it.name, "_w4"}, readdata4, e4);
      end else begin
        checkOutput(it.name, {24'd0, out_port}, it.exp);
        checkOutput({it.name, "_w4"}, {28'd0, out4}, it.exp & 32'hF);
      end
    end
  end

  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (!reset_n) begin
      checkOutput("out_in_reset", {24'd0, out_port}, 32'd0);
      checkOutput("out_in_reset_w4", {28'd0, out4}, 32'd0);
    end else if (outQ.size() > 0) begin
      e = outQ.pop_front();
      checkOutput("out_port", {24'd0, out_port}, e);
      checkOutput("out_port_w4", {28'd0, out4}, e & 32'hF);
    end
  end

  task automatic applyStimulus(input bit cs, input bit wn, input logic [2:0] a,
                               input logic [31:0] d, input string name);
    expItem_t it;
    @(negedge clk);
    address = a; writedata = d; chipselect = cs; write_n = wn;
    if (wn) begin
      #1;
      it.name = name; it.kind = 0; it.addr = a; it.exp = expRead(a);
      rdQ.push_back(it);
      ->rdEv;
    end
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, a, d, "write");
  endtask

  task automatic rd(input logic [2:0] a, input string name);
    applyStimulus(1'($urandom_range(0, 1)), 1'b1, a, $urandom, name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic readAll(input string tag);
    for (int a = 0; a < 8; a++) rd(3'(a), $sformatf("%s_addr%0d", tag, a));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expItem_t it;
    int hi;
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    idle(3);
    readAll("reset");
    @(negedge clk); #2 reset_n = 1'b1;

    wr(3'd0, 32'hA5); wr(3'd1, 32'h0F); idle(2);
    rd(3'd0, "data_after_set"); rd(3'd6, "out_after_set");
    wr(3'd2, 32'h81); rd(3'd0, "data_after_clear");

    wr(3'd0, 32'hFF); wr(3'd3, 32'h0F); wr(3'd4, 32'd3); idle(20);
    rd(3'd4, "period3");
    wr(3'd4, 32'd0); idle(10); rd(3'd6, "out_period0");
    wr(3'd4, 32'd1); idle(10);

`ifdef LED_PIO_PWM_EN
    wr(3'd3, 32'h0); wr(3'd4, 32'h0); wr(3'd0, 32'h01); wr(3'd5, 32'd64);
    rd(3'd5, "duty64"); idle(2);
    hi = 0;
    repeat (256) begin @(negedge clk); if (out_port[0]) hi++; end
    checkOutput("pwm_duty64_high_cycles", 32'(hi), 32'd64);
    wr(3'd5, 32'd0); idle(20); wr(3'd5, 32'd255); idle(20);
`else
    wr(3'd5, 32'h55); rd(3'd5, "duty_absent");
`endif

    wr(3'd0, 32'hFFFF_FFFF); rd(3'd0, "data_all_ones");
    wr(3'd6, 32'h12); wr(3'd7, 32'h34);
    readAll("after_ro_writes");

    wr(3'd0, 32'hFF); wr(3'd3, 32'hFF); wr(3'd4, 32'd100); idle(150);
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    it.name = "out_async_reset"; it.kind = 1; it.addr = 3'd6; it.exp = 32'd0;
    rdQ.push_back(it);
    ->rdEv;
    readAll("midblink_reset");
    @(negedge clk); #2 reset_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      int kind;
      logic [2:0] a;
      logic [31:0] d;
      kind = $urandom_range(0, 3);
      a = 3'($urandom_range(0, 7));
      d = (a == 3'd4 && $urandom_range(0, 7) != 0) ? 32'($urandom_range(0, 5)) : $urandom;
      if (kind <= 1) applyStimulus(1'b1, 1'b0, a, d, "rand_write");
      else if (kind == 2) rd(a, "rand_read");
      else applyStimulus(1'b0, 1'b0, a, d, "rand_unselected");
      idle($urandom_range(0, 4));
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/led_pio_ctrl.md
LED_PIO_CTRL -- requirements
Module: led_pio_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of output channels, legal range 1..32.
REQ-002 SHALL provide parameter PERIOD_W, default 24, blink period register width, legal range 1..32.
REQ-003 SHALL provide port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL provide port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port address  input  3  Avalon-MM word address.
REQ-006 SHALL provide port chipselect  input  1  slave select.
REQ-007 SHALL provide port write_n  input  1  active-low write strobe.
REQ-008 SHALL provide port writedata  input  32  write data; bits above the register width ignored.
REQ-009 SHALL provide port readdata  output  32  read data, zero-extended.
REQ-010 SHALL provide port out_port  output  WIDTH  LED drive, registered.

Function
REQ-011 Write SHALL occur when chipselect=1 and write_n=0; readdata SHALL be combinational from address alone, zero wait states, independent of chipselect.
REQ-012 Address map SHALL be: 0 DATA (rw), 1 SET (wo, reads 0), 2 CLEAR (wo, reads 0), 3 BLINK_MASK (rw), 4 BLINK_PERIOD (rw), 5 DUTY (see Configuration), 6 OUT (ro, current out_port), 7 reserved (reads 0, writes ignored).
REQ-013 A write to SET SHALL do data <= data | writedata[WIDTH-1:0]; a write to CLEAR SHALL do data <= data & ~writedata[WIDTH-1:0].
REQ-014 A write to BLINK_PERIOD SHALL load period, clear blink counter to 0 and set phase to 1 on the same edge.
REQ-015 With period=0, the counter SHALL hold 0 and phase SHALL hold 1 (blink disabled, masked channels steady on when data=1).
REQ-016 With period=P>0, the counter SHALL increment every cycle; on the cycle counter==P it SHALL wrap to 0 and phase SHALL toggle, giving P+1 cycles per phase.
REQ-017 Next out_port bit i SHALL be data[i] & (~mask[i] | phase) & pwm_on, registered, so out_port reflects a register write one cycle after the write edge.
REQ-018 Writes to read-only or reserved addresses SHALL have no effect on any state.

Reset
REQ-019 On reset_n=0, data, mask, counter and out_port SHALL be 0, period SHALL be 0, phase SHALL be 1, DUTY SHALL be 8'hFF, PWM counter SHALL be 0, asynchronously.
REQ-020 Reset asserted mid-blink or mid-PWM SHALL abandon the cycle; first post-reset behaviour SHALL be identical to power-up.

Configuration
REQ-021 Macro LED_PIO_PWM_EN SHALL select global brightness PWM.
REQ-022 With LED_PIO_PWM_EN defined: DUTY (addr 5) SHALL be an 8-bit rw register; an 8-bit free-running counter SHALL increment every cycle, wrapping 255->0; pwm_on SHALL be 1 when DUTY==8'hFF, else (pwm_cnt < DUTY); DUTY=0 SHALL force all outputs off.
REQ-023 Without LED_PIO_PWM_EN: no PWM counter or DUTY register SHALL exist, pwm_on SHALL be constant 1, addr 5 SHALL read 0 and ignore writes.

Verification
REQ-024 Reset, write DATA=0xA5, then SET=0x0F -> DATA reads 0xAF, out_port=0xAF one cycle after SET edge; CLEAR=0x81 -> DATA reads 0x2E.
REQ-025 DATA=0xFF, MASK=0x0F, PERIOD=3 -> out_port low nibble toggles every 4 cycles (0xFF/0xF0), high nibble steady 0xF.
REQ-026 While blinking, write PERIOD=0 -> phase forced 1, out_port=0xFF steady; write PERIOD=1 -> 2-cycle phases from phase 1.
REQ-027 With LED_PIO_PWM_EN, DATA=0x01, DUTY=64 -> out_port[0] high exactly 64 of every 256 cycles; DUTY=0 -> always 0; DUTY=255 -> always 1; without macro addr 5 reads 0.
REQ-028 Assert reset_n mid-blink with PERIOD=100 -> out_port=0 immediately, all registers read reset values, addr 6 reads 0.
REQ-029 WIDTH=4: write DATA=0xFFFFFFFF -> DATA reads 0x0000000F; write to addr 6 and 7 -> no state change.
